// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer with PC, output slot, redirect and halt
//
// Owns the program counter, addresses instruction memory with it, and
// registers each returned word into a one-entry slot consumed by decode
// through a valid/ready handshake.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect with target[1:0] != 0 halts and flags o_misaligned
//   undefined : target[1:0] are cleared; o_misaligned is tied 0
//
// Ports:
//   i_clk              rising-edge clock
//   i_reset            synchronous active-high reset
//   o_imem_address     byte address to instruction memory (registered PC)
//   i_imem_instruction combinational read data for o_imem_address
//   i_redirect_valid   load a new PC this cycle
//   i_redirect_target  byte target of the redirect
//   o_out_valid        output slot holds a valid instruction
//   i_out_ready        decode accepts the slot this cycle
//   o_out_pc           byte address of o_out_instruction
//   o_out_instruction  registered instruction
//   o_halted           sequencer is in HALT
//   o_misaligned       last redirect was trapped as misaligned
//   o_fetch_count      number of accepted handshakes (wraps)

module fetch_sequencer #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          MEM_WORDS = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [63:0] o_imem_address,
  input  logic [31:0] i_imem_instruction,
  input  logic        i_redirect_valid,
  input  logic [63:0] i_redirect_target,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [63:0] o_out_pc,
  output logic [31:0] o_out_instruction,
  output logic        o_halted,
  output logic        o_misaligned,
  output logic [31:0] o_fetch_count
);

  localparam logic [63:0] LP_LIMIT = 64'(MEM_WORDS) * 64'd4;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic        r_out_valid;
  logic [63:0] r_out_pc;
  logic [31:0] r_out_instruction;
  logic        r_halted;
  logic [31:0] r_fetch_count;

  logic        w_slot_free;
  logic        w_accept;
  logic        w_in_range;
  logic [63:0] w_target;

  assign w_slot_free = !r_out_valid || i_out_ready;
  assign w_accept    = r_out_valid && i_out_ready;
  assign w_in_range  = r_pc < LP_LIMIT;
  // Instruction memory ignores address[1:0], so the PC never carries them.
  assign w_target    = i_redirect_target & ~64'h3;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misaligned;
  logic w_target_misaligned;

  assign w_target_misaligned = i_redirect_target[1:0] != 2'b00;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state           <= S_RUN;
      r_pc              <= RESET_PC;
      r_out_valid       <= 1'b0;
      r_out_pc          <= 64'h0;
      r_out_instruction <= 32'h0;
      r_halted          <= 1'b0;
      r_fetch_count     <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misaligned      <= 1'b0;
`endif
    end else begin
      // The handshake counts even when a redirect squashes the slot.
      if (w_accept) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end

      if (i_redirect_valid) begin
        // Redirect beats fetch and halt in either state; nothing is captured.
        r_out_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (w_target_misaligned) begin
          r_state      <= S_HALT;
          r_halted     <= 1'b1;
          r_misaligned <= 1'b1;
        end else begin
          r_pc         <= w_target;
          r_state      <= S_RUN;
          r_halted     <= 1'b0;
          r_misaligned <= 1'b0;
        end
`else
        r_pc     <= w_target;
        r_state  <= S_RUN;
        r_halted <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_RUN: begin
            if (w_slot_free) begin
              if (w_in_range) begin
                r_out_instruction <= i_imem_instruction;
                r_out_pc          <= r_pc;
                r_out_valid       <= 1'b1;
                r_pc              <= r_pc + 64'd4;
              end else begin
                r_out_valid <= 1'b0;
                r_state     <= S_HALT;
                r_halted    <= 1'b1;
              end
            end
          end
          S_HALT: begin
            r_out_valid <= 1'b0;
          end
          default: begin
            r_state <= S_RUN;
          end
        endcase
      end
    end
  end

  assign o_imem_address    = r_pc;
  assign o_out_valid       = r_out_valid;
  assign o_out_pc          = r_out_pc;
  assign o_out_instruction = r_out_instruction;
  assign o_halted          = r_halted;
  assign o_fetch_count     = r_fetch_count;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign o_misaligned      = r_misaligned;
`else
  assign o_misaligned      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instruction;
  logic        halted;
  logic        misaligned;
  logic [31:0] fetch_count;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(64'h0), .MEM_WORDS(256)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .o_imem_address    (imem_address),
    .i_imem_instruction(imem_instruction),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target),
    .o_out_valid       (out_valid),
    .i_out_ready       (out_ready),
    .o_out_pc          (out_pc),
    .o_out_instruction (out_instruction),
    .o_halted          (halted),
    .o_misaligned      (misaligned),
    .o_fetch_count     (fetch_count)
  );

  // Memory contents: word k = {k[11:0], 20'h00013}; outside the array reads garbage.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] k;
    k = a >> 2;
    return (a < 64'd1024) ? {k[11:0], 20'h00013} : 32'hDEADBEEF;
  endfunction

  assign imem_instruction = mem_word(imem_address);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [63:0] rt);
    out_ready       = rdy;
    redirect_valid  = rv;
    redirect_target = rt;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [63:0] rt;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_cnt;
    logic [63:0] e_addr;
    logic        e_halt;
    logic        e_mis;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [63:0] rt,
                              input logic ev, input logic [63:0] ep, input logic [31:0] ei,
                              input logic [31:0] ec, input logic [63:0] ea,
                              input logic eh, input logic em);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rt = rt; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
    v.e_cnt = ec; v.e_addr = ea; v.e_halt = eh; v.e_mis = em;
    return v;
  endfunction

  // Reference model state: an abstract view of the slot and PC.
  logic [63:0] m_pc, m_opc;
  logic [31:0] m_instr, m_cnt;
  logic        m_valid, m_halted, m_mis;

  task automatic model_reset();
    m_pc = 64'h0; m_opc = 64'h0; m_instr = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
  endtask

  task automatic model_step(input logic rdy, input logic rv, input logic [63:0] rt);
    if (m_valid && rdy) m_cnt = m_cnt + 32'd1;
    if (rv) begin
      m_valid = 1'b0;
      if (TRAP && rt[1:0] != 2'b00) begin
        m_halted = 1'b1;
        m_mis    = 1'b1;
      end else begin
        m_pc     = {rt[63:2], 2'b00};
        m_halted = 1'b0;
        m_mis    = 1'b0;
      end
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (!m_valid || rdy) begin
      if (m_pc < 64'd1024) begin
        m_valid = 1'b1;
        m_opc   = m_pc;
        m_instr = mem_word(m_pc);
        m_pc    = m_pc + 64'd4;
      end else begin
        m_valid  = 1'b0;
        m_halted = 1'b1;
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(out_valid), 64'h0);
    chk("reset_pc", out_pc, 64'h0);
    chk("reset_instr", 64'(out_instruction), 64'h0);
    chk("reset_addr", imem_address, 64'h0);
    chk("reset_count", 64'(fetch_count), 64'h0);
    chk("reset_halted", 64'(halted), 64'h0);
    chk("reset_mis", 64'(misaligned), 64'h0);
    reset = 1'b0;

    // Directed table: stream, stall, redirect (+accept), out-of-range halt, resume, misaligned.
    tbl.push_back(mk(1, 0, 0,      1, 64'h0,   32'h00000013, 0, 64'h4,   0, 0));
    tbl.push_back(mk(1, 0, 0,      1, 64'h4,   32'h00100013, 1, 64'h8,   0, 0));
    tbl.push_back(mk(1, 0, 0,      1, 64'h8,   32'h00200013, 2, 64'hC,   0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 0,    1, 64'h8,   32'h00200013, 2, 64'hC,   0, 0));
    tbl.push_back(mk(1, 0, 0,      1, 64'hC,   32'h00300013, 3, 64'h10,  0, 0));
    tbl.push_back(mk(1, 1, 64'h20, 0, 0,       0,            4, 64'h20,  0, 0));
    tbl.push_back(mk(1, 0, 0,      1, 64'h20,  32'h00800013, 4, 64'h24,  0, 0));
    tbl.push_back(mk(1, 0, 0,      1, 64'h24,  32'h00900013, 5, 64'h28,  0, 0));
    tbl.push_back(mk(1, 1, 64'h3FC,0, 0,       0,            6, 64'h3FC, 0, 0));
    tbl.push_back(mk(1, 0, 0,      1, 64'h3FC, 32'h0FF00013, 6, 64'h400, 0, 0));
    tbl.push_back(mk(0, 0, 0,      1, 64'h3FC, 32'h0FF00013, 6, 64'h400, 0, 0));
    tbl.push_back(mk(1, 0, 0,      0, 0,       0,            7, 64'h400, 1, 0));
    tbl.push_back(mk(1, 0, 0,      0, 0,       0,            7, 64'h400, 1, 0));
    tbl.push_back(mk(1, 1, 64'h0,  0, 0,       0,            7, 64'h0,   0, 0));
    tbl.push_back(mk(1, 0, 0,      1, 64'h0,   32'h00000013, 7, 64'h4,   0, 0));
    tbl.push_back(mk(1, 1, 64'h5,  0, 0,       0,            8, 64'h4,   TRAP, TRAP));
    if (TRAP) begin
      tbl.push_back(mk(1, 0, 0,    0, 0,       0,            8, 64'h4,   1, 1));
      tbl.push_back(mk(1, 1, 64'h8,0, 0,       0,            8, 64'h8,   0, 0));
      tbl.push_back(mk(1, 0, 0,    1, 64'h8,   32'h00200013, 8, 64'hC,   0, 0));
    end else begin
      tbl.push_back(mk(1, 0, 0,    1, 64'h4,   32'h00100013, 8, 64'h8,   0, 0));
      tbl.push_back(mk(1, 1, 64'h8,0, 0,       0,            9, 64'h8,   0, 0));
      tbl.push_back(mk(1, 0, 0,    1, 64'h8,   32'h00200013, 9, 64'hC,   0, 0));
    end

    foreach (tbl[i]) begin
      step(tbl[i].rdy, tbl[i].rv, tbl[i].rt);
      chk($sformatf("t%0d_valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("t%0d_pc", i), out_pc, tbl[i].e_pc);
        chk($sformatf("t%0d_instr", i), 64'(out_instruction), 64'(tbl[i].e_instr));
      end
      chk($sformatf("t%0d_count", i), 64'(fetch_count), 64'(tbl[i].e_cnt));
      chk($sformatf("t%0d_addr", i), imem_address, tbl[i].e_addr);
      chk($sformatf("t%0d_halted", i), 64'(halted), 64'(tbl[i].e_halt));
      chk($sformatf("t%0d_mis", i), 64'(misaligned), 64'(tbl[i].e_mis));
    end

    // Reset asserted together with a redirect while streaming: reset wins.
    step(1, 0, 0);
    reset = 1'b1;
    step(1, 1, 64'h100);
    chk("rst_mid_valid", 64'(out_valid), 64'h0);
    chk("rst_mid_addr", imem_address, 64'h0);
    chk("rst_mid_count", 64'(fetch_count), 64'h0);
    chk("rst_mid_halted", 64'(halted), 64'h0);
    reset = 1'b0;
    step(1, 0, 0);
    chk("rst_resume_valid", 64'(out_valid), 64'h1);
    chk("rst_resume_pc", out_pc, 64'h0);

    // Randomized run against the reference model.
    reset = 1'b1;
    step(0, 0, 0);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        rdy, rv;
      logic [63:0] rt;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rt  = 64'($urandom_range(0, 32'h40F));
      if ($urandom_range(0, 3) == 0) rt = 64'h3F0 + 64'($urandom_range(0, 15));
      step(rdy, rv, rt);
      model_step(rdy, rv, rt);
      chk("rnd_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("rnd_pc", out_pc, m_opc);
        chk("rnd_instr", 64'(out_instruction), 64'(m_instr));
      end
      chk("rnd_addr", imem_address, m_pc);
      chk("rnd_count", 64'(fetch_count), 64'(m_cnt));
      chk("rnd_halted", 64'(halted), 64'(m_halted));
      chk("rnd_mis", 64'(misaligned), 64'(m_mis));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
